// File: rtl/lsu_stage.sv
// Load/store unit stage: one memory operation at a time over a req/ready port,
// with alignment/legality checks, byte-lane handling and a REQ timeout.
module lsu_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        out_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  op_f3;
    logic [1:0]  op_ofs;

    logic        illegal;
    logic        misaligned;
    logic        expired;
    logic [3:0]  strb;
    logic [31:0] wlanes;

    always_comb begin
        illegal = (is_load && is_store)
                || (funct3 == 3'b011)
                || (funct3[2:1] == 2'b11)
                || (is_store && funct3[2]);
        misaligned = 1'b0;
        strb = 4'b1111;
        wlanes = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                strb = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                strb = 4'b0011 << addr[1:0];
                wlanes = {2{wdata[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
        expired = (TIMEOUT_CYCLES != 0) && (cnt == TLIM);
    end

    // Shift the selected lane down to bit 0, then extend by size/sign.
    function automatic logic [31:0] extend(
        input logic [2:0]  f3,
        input logic [1:0]  ofs,
        input logic [31:0] w
    );
        logic [31:0] sh;
        sh = w >> {ofs, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            load_data   <= '0;
            fault       <= 1'b0;
            fault_cause <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            cnt         <= '0;
            op_f3       <= '0;
            op_ofs      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_f3    <= funct3;
                        op_ofs   <= addr[1:0];
                        in_ready <= 1'b0;
                        if (!is_load && !is_store) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                        end else if (illegal) begin
                            state       <= RESP;
                            out_valid   <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= 2'b11;
                        end else if (misaligned) begin
                            state       <= RESP;
                            out_valid   <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= 2'b01;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= is_store ? wlanes : '0;
                            mem_wstrb <= is_store ? strb : 4'b0000;
                            cnt       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready || expired) begin
                        state     <= RESP;
                        out_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        cnt       <= '0;
                        if (mem_ready) begin
                            load_data <= mem_we ? '0
                                       : extend(op_f3, op_ofs, mem_rdata);
                        end else begin
                            fault       <= 1'b1;
                            fault_cause <= 2'b10;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    load_data   <= '0;
                    fault       <= 1'b0;
                    fault_cause <= '0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: a transaction-level model predicts each
// cycle's handshake and completion, and a negedge process compares.
module tb_lsu_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        out_valid;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .out_valid(out_valid), .load_data(load_data),
        .fault(fault), .fault_cause(fault_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    int          cfg_wt = -1;
    logic [31:0] cfg_rd = '0;
    bit          stray = 1'b0;
    int          wcnt = 0;

    bit          m_acc, m_flt, m_we;
    int          m_n;
    logic [1:0]  m_cause;
    logic [31:0] m_ld, m_wd, m_addr;
    logic [3:0]  m_strb;
    int          e_a = -100;
    int          e_d = -100;

    int          rq_cnt = 0;
    logic [31:0] got_ld, got_addr, got_wd;
    logic [3:0]  got_strb;
    logic        got_flt;
    logic [1:0]  got_cause;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      nm, got, exp, cyc);
    endtask

    // Outcome of one operation, straight from the access rules.
    function automatic void model(input bit ld, input bit st,
                                  input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] wd,
                                  input int wt,
                                  input logic [31:0] rd);
        int sz, off;
        longint v;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(a % 4);
        m_acc = 0; m_flt = 0; m_cause = 0; m_ld = 0; m_n = 0;
        m_we = st; m_addr = a - (a % 4); m_strb = 0; m_wd = 0;
        if (!ld && !st) return;
        if ((ld && st) || f3 == 3 || f3 == 6 || f3 == 7 || (st && f3 >= 4)) begin
            m_flt = 1; m_cause = 2'b11; return;
        end
        if (off % sz != 0) begin
            m_flt = 1; m_cause = 2'b01; return;
        end
        m_acc = 1;
        if (wt >= 0 && wt <= TMO - 1) m_n = wt + 1;
        else begin
            m_n = TMO; m_flt = 1; m_cause = 2'b10; return;
        end
        if (st) begin
            m_strb = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++)
                m_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
        end else begin
            v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
            if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
                v = v - (64'd1 << (8 * sz));
            m_ld = v[31:0];
        end
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: ready after cfg_wt wait cycles; stray ready when idle.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            mem_ready = (cfg_wt >= 0 && wcnt == cfg_wt);
            mem_rdata = mem_ready ? cfg_rd : ~cfg_rd;
            wcnt++;
        end else begin
            mem_ready = stray;
            mem_rdata = ~cfg_rd;
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit busy, reqw, done;
            busy = (cyc >= e_a) && (cyc <= e_d);
            reqw = m_acc && (cyc >= e_a) && (cyc < e_a + m_n);
            done = (cyc == e_d);
            if (mem_req) rq_cnt++;
            chk("in_ready", 32'(in_ready), 32'(!busy));
            chk("mem_req", 32'(mem_req), 32'(reqw));
            if (reqw) begin
                chk("mem_we", 32'(mem_we), 32'(m_we));
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(m_strb));
                if (m_we) chk("mem_wdata", mem_wdata, m_wd);
                got_addr = mem_addr; got_wd = mem_wdata; got_strb = mem_wstrb;
            end
            chk("out_valid", 32'(out_valid), 32'(done));
            chk("fault", 32'(fault), done ? 32'(m_flt) : 32'd0);
            chk("fault_cause", 32'(fault_cause), done ? 32'(m_cause) : 32'd0);
            chk("load_data", load_data, done ? m_ld : 32'd0);
            if (done) begin
                got_ld = load_data; got_flt = fault; got_cause = fault_cause;
            end
        end
    end

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int wt, input logic [31:0] rd);
        @(posedge clk); #1;
        cfg_wt = wt; cfg_rd = rd;
        model(ld, st, f3, a, wd, wt, rd);
        e_a = cyc + 1;
        e_d = e_a + (m_acc ? m_n : 0);
        rq_cnt = 0;
        in_valid = 1; is_load = ld; is_store = st;
        funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        in_valid = 0; is_load = 0; is_store = 0;
        funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'hA5A5_A5A5;
        repeat (e_d + 1 - e_a) @(posedge clk);
    endtask

    initial begin
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst fault_cause", 32'(fault_cause), 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(negedge clk); #2;
        rst_n = 1;
        chk_en = 1;

        // LB sign-extended, ready at first REQ cycle
        run_op(1, 0, 3'b000, 32'h0000_1003, 0, 0, 32'h8000_0000);
        chk("lb addr", got_addr, 32'h0000_1000);
        chk("lb data", got_ld, 32'hFFFF_FF80);
        chk("lb req cycles", 32'(rq_cnt), 32'd1);

        run_op(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 1, 0);
        chk("sh strb", 32'(got_strb), 32'h0000_000C);
        chk("sh wdata", got_wd, 32'hABCD_ABCD);
        chk("sh data", got_ld, 32'd0);

        run_op(1, 0, 3'b010, 32'h0000_0006, 0, 0, 0);
        chk("lw misal cause", 32'(got_cause), 32'd1);
        chk("lw misal req", 32'(rq_cnt), 32'd0);

        run_op(1, 0, 3'b010, 32'h0000_0100, 0, -1, 0);
        chk("tmo cause", 32'(got_cause), 32'd2);
        chk("tmo req cycles", 32'(rq_cnt), 32'd4);

        // Ready on the last allowed cycle completes normally
        run_op(1, 0, 3'b101, 32'h0000_0002, 0, 3, 32'hBEEF_0000);
        chk("lhu data", got_ld, 32'h0000_BEEF);
        chk("lhu fault", 32'(got_flt), 32'd0);
        chk("lhu req cycles", 32'(rq_cnt), 32'd4);

        run_op(1, 0, 3'b001, 32'h0000_0002, 0, 1, 32'h8001_0000);
        chk("lh data", got_ld, 32'hFFFF_8001);
        run_op(1, 0, 3'b100, 32'h0000_1001, 0, 0, 32'h0000_AB00);
        chk("lbu data", got_ld, 32'h0000_00AB);
        run_op(0, 1, 3'b000, 32'h0000_3001, 32'h0000_0055, 0, 0);
        chk("sb strb", 32'(got_strb), 32'h0000_0002);
        chk("sb wdata", got_wd, 32'h5555_5555);
        run_op(0, 1, 3'b010, 32'h0000_3004, 32'hDEAD_BEEF, 2, 0);
        run_op(1, 0, 3'b010, 32'h0000_3008, 0, 0, 32'h1357_9BDF);
        chk("lw data", got_ld, 32'h1357_9BDF);

        run_op(0, 0, 3'b010, 32'h0000_0004, 0, 0, 0);
        chk("nop fault", 32'(got_flt), 32'd0);
        run_op(1, 1, 3'b010, 32'h0000_0004, 0, 0, 0);
        chk("both cause", 32'(got_cause), 32'd3);
        run_op(0, 1, 3'b100, 32'h0000_0004, 0, 0, 0);
        run_op(1, 0, 3'b011, 32'h0000_0008, 0, 0, 0);
        run_op(1, 0, 3'b111, 32'h0000_0001, 0, 0, 0);
        chk("illegal over misal", 32'(got_cause), 32'd3);
        run_op(0, 1, 3'b101, 32'h0000_0001, 0, 0, 0);
        run_op(1, 0, 3'b001, 32'h0000_0001, 0, 0, 0);
        chk("lh misal cause", 32'(got_cause), 32'd1);

        stray = 1;
        run_op(1, 0, 3'b000, 32'h0000_0040, 0, 2, 32'h0000_007F);
        chk("stray ready data", got_ld, 32'h0000_007F);
        chk("stray req cycles", 32'(rq_cnt), 32'd3);
        stray = 0;

        // Reset in the middle of a REQ wait
        @(posedge clk); #1;
        cfg_wt = -1;
        model(1, 0, 3'b010, 32'h0000_0080, 0, -1, 0);
        e_a = cyc + 1; e_d = e_a + m_n;
        in_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h0000_0080;
        @(posedge clk); #1;
        in_valid = 0; is_load = 0;
        @(posedge clk); #1;
        chk_en = 0;
        chk("pre-rst mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("async mem_req", 32'(mem_req), 32'd0);
        chk("async in_ready", 32'(in_ready), 32'd1);
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async mem_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        e_a = -100; e_d = -100; m_acc = 0;
        chk_en = 1;
        repeat (6) @(posedge clk);

        run_op(1, 0, 3'b000, 32'h0000_0011, 0, 0, 32'h0000_FE00);
        chk("post-rst data", got_ld, 32'hFFFF_FFFE);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
